// File: rtl/counter_pkg.sv
// counter_pkg: definitions shared by the counter RTL and counter_monitor.
//   state_t    - monitor FSM states (IDLE, ACQ, LOCKED)
//   next_value - next count of a wrapping up/down counter with sync clear
//   is_wrap    - true when that next count crosses the MAX/0 boundary
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // The wrap is an explicit compare against max_val, so the result does not
  // depend on the counter width overflowing naturally.
  function automatic logic [31:0] next_value(input logic [31:0] value,
                                             input logic        mode,
                                             input logic        clr,
                                             input logic [31:0] max_val);
    if (clr)        return 32'd0;
    else if (!mode) return (value == max_val) ? 32'd0 : value + 32'd1;
    else            return (value == 32'd0) ? max_val : value - 32'd1;
  endfunction

  function automatic logic is_wrap(input logic [31:0] value,
                                   input logic        mode,
                                   input logic        clr,
                                   input logic [31:0] max_val);
    if (clr)        return 1'b0;
    else if (!mode) return value == max_val;
    else            return value == 32'd0;
  endfunction

endpackage

// File: rtl/counter_predict.sv
// counter_predict: combinational next-value predictor for the observed counter.
//   value     in  WIDTH  current counter value
//   mode      in  1      0 = up, 1 = down
//   clr       in  1      counter clear accompanies this value
//   next      out WIDTH  predicted following value
//   next_wrap out 1      the predicted step crosses MAX_VAL <-> 0
module counter_predict
  import counter_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int MAX_VAL = 999
) (
  input  logic [WIDTH-1:0] value,
  input  logic             mode,
  input  logic             clr,
  output logic [WIDTH-1:0] next,
  output logic             next_wrap
);

  logic [31:0] next_full;

  assign next_full = next_value(32'(value), mode, clr, 32'(MAX_VAL));
  assign next      = next_full[WIDTH-1:0];
  assign next_wrap = is_wrap(32'(value), mode, clr, 32'(MAX_VAL));

endmodule

// File: rtl/counter_monitor.sv
// counter_monitor: watches samples of an external wrapping up/down counter,
// acquires lock after LOCK_LEN consecutive correctly predicted samples and
// flags deviations.
//   clk, rst   clock, asynchronous active-high reset
//   cnt_valid  qualifies cnt_in/mode/src_clr (no backpressure: a sample is
//              consumed on every rising edge where cnt_valid is high)
//   cnt_in     observed value; mode 0 = up, 1 = down; src_clr = counter cleared
//   locked     FSM is in LOCKED
//   err_pulse  one cycle per error; err_sticky holds until rst;
//   err_count  saturating 8-bit error count
//   wrap_pulse matched sample crossed MAX_VAL <-> 0
//   state_dbg  current FSM state (counter_pkg::state_t encoding)
// All outputs are registered: they reflect a sample one cycle after it.
module counter_monitor
  import counter_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int MAX_VAL  = 999,
  parameter int LOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_valid,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             mode,
  input  logic             src_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [7:0]       err_count,
  output logic             wrap_pulse,
  output logic [1:0]       state_dbg
);

  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [3:0]       LOCK_W = 4'(LOCK_LEN);

  state_t           state, state_n;
  logic [WIDTH-1:0] pred, pred_n;
  logic             pred_wrap, pred_wrap_n;   // pred was reached by wrapping
  logic [3:0]       match_cnt, match_n;
  logic             err_p_n, wrap_p_n, sticky_n;
  logic [7:0]       count_n;

  logic [WIDTH-1:0] nxt;
  logic             nxt_wrap;
  logic             out_of_range, hit;

  counter_predict #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_predict (
    .value     (cnt_in),
    .mode      (mode),
    .clr       (src_clr),
    .next      (nxt),
    .next_wrap (nxt_wrap)
  );

  assign out_of_range = cnt_in > MAX_W;
  assign hit          = cnt_in == pred;
  assign state_dbg    = state;

  always_comb begin
    state_n     = state;
    pred_n      = pred;
    pred_wrap_n = pred_wrap;
    match_n     = match_cnt;
    err_p_n     = 1'b0;
    wrap_p_n    = 1'b0;
    sticky_n    = err_sticky;
    count_n     = err_count;
    if (cnt_valid) begin
      if (out_of_range) begin
        // Counts as a single error even if it also mismatches; never a seed.
        err_p_n = 1'b1;
        match_n = 4'd0;
        state_n = ST_IDLE;
      end else begin
        // Every in-range sample becomes the base of the next prediction.
        pred_n      = nxt;
        pred_wrap_n = nxt_wrap;
        case (state)
          ST_IDLE: begin
            match_n = 4'd0;
            state_n = ST_ACQ;
          end
          ST_ACQ: begin
            if (hit) begin
              match_n  = match_cnt + 4'd1;
              wrap_p_n = pred_wrap;
              if (match_cnt + 4'd1 >= LOCK_W) state_n = ST_LOCKED;
            end else begin
              match_n = 4'd0;
            end
          end
          ST_LOCKED: begin
            if (hit) begin
              wrap_p_n = pred_wrap;
            end else begin
              err_p_n = 1'b1;
              match_n = 4'd0;
              state_n = ST_ACQ;
            end
          end
          default: begin
            match_n = 4'd0;
            state_n = ST_IDLE;
          end
        endcase
      end
      if (err_p_n) begin
        sticky_n = 1'b1;
        if (err_count != 8'hFF) count_n = err_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pred       <= '0;
      pred_wrap  <= 1'b0;
      match_cnt  <= 4'd0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= 8'd0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      pred       <= pred_n;
      pred_wrap  <= pred_wrap_n;
      match_cnt  <= match_n;
      locked     <= (state_n == ST_LOCKED);
      err_pulse  <= err_p_n;
      err_sticky <= sticky_n;
      err_count  <= count_n;
      wrap_pulse <= wrap_p_n;
    end
  end

endmodule

// File: tb/tb_counter_monitor.sv
module tb_counter_monitor;

  localparam int WIDTH = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cnt_valid = 1'b0;
  logic [WIDTH-1:0] cnt_in = '0;
  logic             mode = 1'b0;
  logic             src_clr = 1'b0;
  logic             locked, err_pulse, err_sticky, wrap_pulse;
  logic [7:0]       err_count;
  logic [1:0]       state_dbg;

  int errors = 0;
  int checks = 0;

  counter_monitor #(.WIDTH(WIDTH), .MAX_VAL(999), .LOCK_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_valid  (cnt_valid),
    .cnt_in     (cnt_in),
    .mode       (mode),
    .src_clr    (src_clr),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .wrap_pulse (wrap_pulse),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    cnt_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // drivers: one sample per cycle; outputs are examined 1 ns after the edge
  task automatic send(input int v, input logic m, input logic c);
    @(negedge clk);
    cnt_valid = 1'b1;
    cnt_in    = WIDTH'(v);
    mode      = m;
    src_clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    cnt_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%0b exp=0", locked); end
    checks++; if (err_pulse !== 1'b0 || err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b%0b exp=00", err_pulse, err_sticky); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", err_count); end
    checks++; if (wrap_pulse !== 1'b0 || state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got=%0b/%0d exp=0/0", wrap_pulse, state_dbg); end
  endtask

  task automatic test_lock();
    do_reset();
    send(5, 0, 0);
    checks++; if (state_dbg !== 2'd1 || err_pulse !== 1'b0) begin errors++; $display("FAIL lock_seed state=%0d err=%0b exp=1/0", state_dbg, err_pulse); end
    send(6, 0, 0); send(7, 0, 0); send(8, 0, 0);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early got=%0b exp=0", locked); end
    send(9, 0, 0);
    checks++; if (locked !== 1'b1 || state_dbg !== 2'd2) begin errors++; $display("FAIL lock_9 locked=%0b state=%0d exp=1/2", locked, state_dbg); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL lock_count got=%0d exp=0", err_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int v = 995; v <= 999; v++) send(v, 0, 0);
    checks++; if (locked !== 1'b1 || wrap_pulse !== 1'b0) begin errors++; $display("FAIL wrap_pre locked=%0b wrap=%0b exp=1/0", locked, wrap_pulse); end
    send(0, 0, 0);
    checks++; if (wrap_pulse !== 1'b1 || err_pulse !== 1'b0) begin errors++; $display("FAIL wrap_up wrap=%0b err=%0b exp=1/0", wrap_pulse, err_pulse); end
    send(1, 1, 0);
    checks++; if (wrap_pulse !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL wrap_after wrap=%0b locked=%0b exp=0/1", wrap_pulse, locked); end
    send(0, 1, 0);
    send(999, 1, 0);
    checks++; if (wrap_pulse !== 1'b1 || err_pulse !== 1'b0 || locked !== 1'b1) begin errors++; $display("FAIL wrap_down wrap=%0b err=%0b locked=%0b exp=1/0/1", wrap_pulse, err_pulse, locked); end
    idle(3);
    checks++; if (wrap_pulse !== 1'b0 || locked !== 1'b1 || state_dbg !== 2'd2) begin errors++; $display("FAIL idle_hold wrap=%0b locked=%0b state=%0d exp=0/1/2", wrap_pulse, locked, state_dbg); end
    send(998, 1, 0);
    checks++; if (locked !== 1'b1 || err_pulse !== 1'b0) begin errors++; $display("FAIL idle_resume locked=%0b err=%0b exp=1/0", locked, err_pulse); end
  endtask

  task automatic test_mismatch();
    do_reset();
    for (int v = 6; v <= 10; v++) send(v, 0, 0);
    send(12, 0, 0);
    checks++; if (err_pulse !== 1'b1 || err_count !== 8'd1 || err_sticky !== 1'b1) begin errors++; $display("FAIL mm_err pulse=%0b count=%0d sticky=%0b exp=1/1/1", err_pulse, err_count, err_sticky); end
    checks++; if (locked !== 1'b0 || state_dbg !== 2'd1) begin errors++; $display("FAIL mm_state locked=%0b state=%0d exp=0/1", locked, state_dbg); end
    send(13, 0, 0);
    checks++; if (err_pulse !== 1'b0 || err_sticky !== 1'b1) begin errors++; $display("FAIL mm_pulse_len pulse=%0b sticky=%0b exp=0/1", err_pulse, err_sticky); end
    send(14, 0, 0); send(15, 0, 0); send(16, 0, 0);
    checks++; if (locked !== 1'b1 || err_count !== 8'd1) begin errors++; $display("FAIL mm_relock locked=%0b count=%0d exp=1/1", locked, err_count); end
  endtask

  // continues from the relocked state of test_mismatch (prediction 17)
  task automatic test_out_of_range();
    send(1000, 0, 0);
    checks++; if (err_pulse !== 1'b1 || err_count !== 8'd2 || state_dbg !== 2'd0 || locked !== 1'b0) begin errors++; $display("FAIL oor pulse=%0b count=%0d state=%0d locked=%0b exp=1/2/0/0", err_pulse, err_count, state_dbg, locked); end
    send(3, 0, 0);
    checks++; if (err_pulse !== 1'b0 || err_count !== 8'd2 || state_dbg !== 2'd1) begin errors++; $display("FAIL oor_seed pulse=%0b count=%0d state=%0d exp=0/2/1", err_pulse, err_count, state_dbg); end
    send(4, 0, 0);
    checks++; if (err_pulse !== 1'b0 || state_dbg !== 2'd1) begin errors++; $display("FAIL oor_follow pulse=%0b state=%0d exp=0/1", err_pulse, state_dbg); end
  endtask

  task automatic test_src_clr();
    do_reset();
    for (int v = 496; v <= 499; v++) send(v, 0, 0);
    send(500, 0, 1);
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clr_lock got=%0b exp=1", locked); end
    send(0, 0, 0);
    checks++; if (err_pulse !== 1'b0 || locked !== 1'b1 || wrap_pulse !== 1'b0) begin errors++; $display("FAIL clr_match err=%0b locked=%0b wrap=%0b exp=0/1/0", err_pulse, locked, wrap_pulse); end
    do_reset();
    for (int v = 496; v <= 499; v++) send(v, 0, 0);
    send(500, 0, 1);
    send(501, 0, 0);
    checks++; if (err_pulse !== 1'b1 || err_count !== 8'd1) begin errors++; $display("FAIL clr_mismatch pulse=%0b count=%0d exp=1/1", err_pulse, err_count); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int v = 10; v <= 14; v++) send(v, 0, 0);
    for (int i = 1; i <= 256; i++) begin
      send(100, 0, 0);  // mismatch while locked
      if (i == 255) begin
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_255 got=%0d exp=255", err_count); end
      end
      for (int v = 101; v <= 104; v++) send(v, 0, 0);
    end
    checks++; if (err_count !== 8'd255 || err_sticky !== 1'b1) begin errors++; $display("FAIL sat_hold count=%0d sticky=%0b exp=255/1", err_count, err_sticky); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_relock got=%0b exp=1", locked); end
  endtask

  task automatic test_reset_mid_acq();
    do_reset();
    send(1000, 0, 0);
    send(20, 0, 0);
    send(21, 0, 0);
    checks++; if (err_sticky !== 1'b1 || state_dbg !== 2'd1) begin errors++; $display("FAIL mid_pre sticky=%0b state=%0d exp=1/1", err_sticky, state_dbg); end
    // cnt_valid stays high; reset lands between clock edges
    #2 rst = 1'b1;
    #1;
    checks++; if (err_sticky !== 1'b0 || err_count !== 8'd0 || err_pulse !== 1'b0 || state_dbg !== 2'd0 || locked !== 1'b0 || wrap_pulse !== 1'b0) begin errors++; $display("FAIL mid_async sticky=%0b count=%0d pulse=%0b state=%0d exp=0/0/0/0", err_sticky, err_count, err_pulse, state_dbg); end
    @(negedge clk);
    rst = 1'b0;
    send(22, 0, 0);
    checks++; if (err_pulse !== 1'b0 || state_dbg !== 2'd1 || err_count !== 8'd0) begin errors++; $display("FAIL mid_seed pulse=%0b state=%0d count=%0d exp=0/1/0", err_pulse, state_dbg, err_count); end
    send(30, 0, 0);  // mismatch during ACQ is not an error
    checks++; if (err_pulse !== 1'b0 || err_sticky !== 1'b0 || state_dbg !== 2'd1) begin errors++; $display("FAIL acq_mismatch pulse=%0b sticky=%0b state=%0d exp=0/0/1", err_pulse, err_sticky, state_dbg); end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_mismatch();
    test_out_of_range();
    test_src_clr();
    test_saturation();
    test_reset_mid_acq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
